// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver for an 11-bit frame
// (start, 8 data bits LSB first, even parity, stop).
// Ports:
//   sys_clk      - single clock, rising edge
//   reset        - synchronous, active-high
//   data_rx      - asynchronous serial input, idle high
//   data_out     - last received byte, held until the next frame completes
//   done_flag    - one-cycle pulse per completed frame (errored frames included)
//   active_flag  - high while a frame is being received
//   parity_error - received parity differs from ^data, updated with done_flag
//   frame_error  - stop bit sampled low, updated with done_flag
module uart_rx #(
    parameter int unsigned SYS_CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE    = 9600
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       data_rx,
    output logic [7:0] data_out,
    output logic       done_flag,
    output logic       active_flag,
    output logic       parity_error,
    output logic       frame_error
);

    localparam int unsigned DIV   = SYS_CLK_FREQ / (BAUD_RATE * 16);
    localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic             rx_meta, rx_sync, rx_prev;
    logic             start_edge;
    logic [CNT_W-1:0] tick_cnt, tick_cnt_next;
    logic             tick;
    logic [3:0]       samp_cnt, samp_cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       data_reg, data_reg_next;
    logic             par_bit, par_bit_next;
    logic             frame_end;
    logic [2:0]       state, state_next;

    // Two-flop synchronizer plus a history flop for falling-edge detection
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= data_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_edge = rx_prev & ~rx_sync;
    assign tick       = (tick_cnt == CNT_W'(DIV - 1));

    // State and datapath registers
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            samp_cnt <= '0;
            bit_idx  <= '0;
            data_reg <= '0;
            par_bit  <= 1'b0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_cnt_next;
            samp_cnt <= samp_cnt_next;
            bit_idx  <= bit_idx_next;
            data_reg <= data_reg_next;
            par_bit  <= par_bit_next;
        end
    end

    // Next-state and datapath update; samp_cnt==15 on a tick marks the 16th tick
    always_comb begin
        state_next    = state;
        tick_cnt_next = tick ? '0 : CNT_W'(tick_cnt + 1'b1);
        samp_cnt_next = samp_cnt;
        bit_idx_next  = bit_idx;
        data_reg_next = data_reg;
        par_bit_next  = par_bit;
        frame_end     = 1'b0;
        case (state)
            IDLE: begin
                tick_cnt_next = '0;
                samp_cnt_next = '0;
                bit_idx_next  = '0;
                if (start_edge) state_next = START;
            end
            START: begin
                if (tick) begin
                    if (samp_cnt == 4'd7) begin
                        samp_cnt_next = '0;
                        // Line back high at mid start bit: glitch, not a frame
                        state_next = rx_sync ? IDLE : DATA;
                    end else begin
                        samp_cnt_next = 4'(samp_cnt + 4'd1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    samp_cnt_next = 4'(samp_cnt + 4'd1);
                    if (samp_cnt == 4'd15) begin
                        data_reg_next[bit_idx] = rx_sync;
                        bit_idx_next           = 3'(bit_idx + 3'd1);
                        if (bit_idx == 3'd7) state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    samp_cnt_next = 4'(samp_cnt + 4'd1);
                    if (samp_cnt == 4'd15) begin
                        par_bit_next = rx_sync;
                        state_next   = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    samp_cnt_next = 4'(samp_cnt + 4'd1);
                    if (samp_cnt == 4'd15) begin
                        frame_end  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs; active_flag drops on the same edge done_flag rises
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            data_out     <= 8'h00;
            done_flag    <= 1'b0;
            active_flag  <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            done_flag   <= frame_end;
            active_flag <= (state_next != IDLE);
            if (frame_end) begin
                data_out     <= data_reg;
                parity_error <= par_bit ^ (^data_reg);
                frame_error  <= ~rx_sync;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives bit-accurate serial frames into uart_rx and checks
// the received records against a frame-level reference model.
module tb_uart_rx;

    localparam int unsigned BIT_CYC  = 160;   // 1_600_000 / 10_000
    localparam int unsigned DONE_LAT = 1683;  // 3 detect + 168 ticks * 10

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } rec_t;

    logic       clk;
    logic       reset;
    logic       data_rx;
    logic [7:0] data_out;
    logic       done_flag;
    logic       active_flag;
    logic       parity_error;
    logic       frame_error;

    int   cyc;
    int   n_checks;
    int   n_fail;
    int   width_viol;
    logic done_prev;
    rec_t mon_rec;
    rec_t got_q[$];
    rec_t exp_q[$];
    logic [7:0] last_byte;

    uart_rx #(
        .SYS_CLK_FREQ(1_600_000),
        .BAUD_RATE   (10_000)
    ) dut (
        .sys_clk     (clk),
        .reset       (reset),
        .data_rx     (data_rx),
        .data_out    (data_out),
        .done_flag   (done_flag),
        .active_flag (active_flag),
        .parity_error(parity_error),
        .frame_error (frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Capture every done pulse away from the active edge
    initial begin
        width_viol = 0;
        done_prev  = 1'b0;
    end
    always @(negedge clk) begin
        if (done_flag) begin
            mon_rec.cyc = cyc;
            mon_rec.d   = data_out;
            mon_rec.pe  = parity_error;
            mon_rec.fe  = frame_error;
            got_q.push_back(mon_rec);
            if (done_prev) width_viol++;
        end
        done_prev = done_flag;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Serial model: drives one full frame and records what the receiver must report
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        logic [10:0] bits;
        int          fall;
        int          act_lows;
        rec_t        r;
        bits     = {stp, par, d, 1'b0};
        act_lows = 0;
        fall     = cyc;
        for (int b = 0; b < 11; b++) begin
            data_rx = bits[b];
            for (int i = 0; i < int'(BIT_CYC); i++) begin
                if (i == 80 && !active_flag) act_lows++;
                @(posedge clk);
                #1;
            end
        end
        r.cyc = fall + int'(DONE_LAT);
        r.d   = d;
        r.pe  = par ^ (^d);
        r.fe  = ~stp;
        exp_q.push_back(r);
        last_byte = d;
        check_eq("active_hold", act_lows, 0);
    endtask

    task automatic compare_frames(input string tag);
        rec_t g, e;
        int   lat_ok;
        wait_cyc(5);
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            lat_ok = (g.cyc >= e.cyc - 2 && g.cyc <= e.cyc + 2) ? 1 : 0;
            check_eq({tag, "_data"}, g.d, e.d);
            check_eq({tag, "_perr"}, g.pe, e.pe);
            check_eq({tag, "_ferr"}, g.fe, e.fe);
            check_eq({tag, "_latency_ok"}, lat_ok, 1);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_data_out"}, data_out, 0);
        check_eq({tag, "_done"}, done_flag, 0);
        check_eq({tag, "_active"}, active_flag, 0);
        check_eq({tag, "_perr"}, parity_error, 0);
        check_eq({tag, "_ferr"}, frame_error, 0);
    endtask

    initial begin
        logic [7:0] d;
        logic       par, stp;
        logic [7:0] abort_byte;
        int         seen_active;
        int         gap;

        n_checks  = 0;
        n_fail    = 0;
        last_byte = 8'h00;
        reset     = 1'b1;
        data_rx   = 1'b1;
        wait_cyc(4);
        reset = 1'b0;
        wait_cyc(2);
        check_idle_outputs("reset");

        // Single byte
        send_frame(8'hA5, 1'b0, 1'b1);
        compare_frames("single");

        // Parity error
        send_frame(8'h3C, 1'b1, 1'b1);
        compare_frames("parity");

        // Framing error, line held low afterwards must not re-arm
        send_frame(8'h81, 1'b0, 1'b0);
        wait_cyc(2 * int'(BIT_CYC));
        check_eq("ferr_low_active", active_flag, 0);
        compare_frames("framing");
        data_rx = 1'b1;
        wait_cyc(200);
        check_eq("ferr_no_rearm", got_q.size(), 0);

        // Glitch: 40 cycles low is rejected at the start-bit sample
        seen_active = 0;
        data_rx = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (i == 40) data_rx = 1'b1;
            @(posedge clk);
            #1;
            if (active_flag) seen_active = 1;
        end
        check_eq("glitch_seen_active", seen_active, 1);
        check_eq("glitch_active_end", active_flag, 0);
        check_eq("glitch_no_done", got_q.size(), 0);
        check_eq("glitch_data_hold", data_out, last_byte);
        exp_q.delete();

        // Back-to-back frames
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        wait_cyc(5);
        if (got_q.size() >= 2)
            check_eq("b2b_gap", got_q[1].cyc - got_q[0].cyc, 10 * 176);
        else
            check_eq("b2b_cnt", got_q.size(), 2);
        compare_frames("b2b");

        // Reset during data bit 4 of 0x55, then a clean frame
        abort_byte = 8'h55;
        data_rx = 1'b0;
        wait_cyc(BIT_CYC);
        for (int k = 0; k < 4; k++) begin
            data_rx = abort_byte[k];
            wait_cyc(BIT_CYC);
        end
        data_rx = abort_byte[4];
        wait_cyc(80);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        check_idle_outputs("midreset");
        last_byte = 8'h00;
        data_rx   = 1'b1;
        wait_cyc(400);
        check_eq("midreset_no_done", got_q.size(), 0);
        send_frame(8'h12, 1'b0, 1'b1);
        compare_frames("after_reset");

        // Randomized frames with occasional parity/stop errors and random gaps
        for (int n = 0; n < 10; n++) begin
            d   = 8'($urandom_range(0, 255));
            par = (^d) ^ ($urandom_range(0, 3) == 0);
            stp = ($urandom_range(0, 3) != 0);
            send_frame(d, par, stp);
            gap = stp ? int'($urandom_range(0, 100)) : 16 + int'($urandom_range(0, 100));
            data_rx = 1'b1;
            wait_cyc(gap);
        end
        compare_frames("rand");

        check_eq("done_width", width_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: the receive-side counterpart of the team's `tx` transmitter, recovering the same 11-bit frame from a serial line. The frame is one start bit, 8 data bits sent LSB first, one even-parity bit, and one stop bit. The block oversamples the asynchronous `data_rx` line at 16x baud using an internal tick divider. It presents each received byte with one-cycle `done_flag` strobes and parity/framing error flags.

## Interface
Parameters:
- `SYS_CLK_FREQ`, default 50_000_000: sys_clk frequency in Hz.
- `BAUD_RATE`, default 9600: line rate in bit/s.
- Derived localparam `DIV = SYS_CLK_FREQ / (BAUD_RATE*16)`, integer-truncated (325 at defaults); must be ≥ 2.

Ports:
- `sys_clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `data_rx` in 1: asynchronous serial input; idle high.
- `data_out` out 8: last received byte; holds its value until the next frame completes.
- `done_flag` out 1: one-cycle pulse when a frame completes, including errored frames.
- `active_flag` out 1: high while a frame is being received.
- `parity_error` out 1: updated with `done_flag`; 1 if the received parity ≠ ^data.
- `frame_error` out 1: updated with `done_flag`; 1 if the stop bit was sampled 0.

## Operation
- **Synchronizer:** `data_rx` passes through a 2-FF synchronizer; both flops reset to 1. A third flop holds the previous synced value for edge detection.
- **Tick generator:** counter 0..DIV-1. `tick` is high for one cycle when the counter equals DIV-1. The counter is held at 0 in IDLE and starts from 0 on start detection.
- **Sample counter:** 4-bit, counts ticks within a bit. A bit index of 0..7 tracks the data bits.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: go to START on a synced 1→0 edge (previous = 1, current = 0). A line held low never re-arms.
  - START: at tick 8, sample the line. If 1, this is a false start: go to IDLE with no flags. If 0, clear the sample counter and go to DATA.
  - DATA: at every 16th tick, shift the sample into bit[index], LSB first. After index 7, go to PARITY.
  - PARITY: at the 16th tick, capture the parity bit and go to STOP.
  - STOP: at the 16th tick, sample the stop bit, then:
    - load `data_out`;
    - set `parity_error = parity ^ (^data)`;
    - set `frame_error = ~stop`;
    - pulse `done_flag`;
    - go to IDLE.
- **Frame errors:** no resynchronisation wait; the next 1→0 edge starts a new frame.
- **Status outputs:**
  - `active_flag` = 1 in START, DATA, PARITY and STOP; 0 in IDLE.
  - `parity_error` and `frame_error` hold until the next `done_flag`.
- **Reset (including mid-frame):** in the next cycle, FSM = IDLE, all counters = 0, `data_out` = 0x00, and all flags = 0. No `done_flag` is issued for the aborted frame.

## Timing
- Start detection occurs 3 sys_clk cycles after `data_rx` falls: 2 synchronizer cycles plus the edge flop.
- Sample points, in ticks counted from start detection:
  - start bit: 8;
  - data bit k (k = 0..7): 24+16k;
  - parity: 152;
  - stop: 168.
- One tick = DIV sys_clk cycles, so the stop sample falls at 168·DIV cycles after detection.
- `done_flag`, `data_out` and the error flags are registered outputs. They change in the cycle after the stop-sample tick. `done_flag` is high for exactly 1 cycle.
- `active_flag` rises in the cycle after detection. It falls in the same cycle that `done_flag` rises.
- Back-to-back frames need no idle gap beyond the full stop bit: a start edge arriving 8 ticks after the stop sample is accepted.
- Baud tolerance: each sample lands within ±1 tick of bit centre. This gives correct reception up to about ±3% rate mismatch.

## Test plan
Bench settings: `SYS_CLK_FREQ`=1_600_000, `BAUD_RATE`=10_000, so DIV = 10 and one bit time = 160 cycles. The bench drives frames from a bit-accurate serial model.

1. **Single byte:** send 0xA5 with parity 0 and stop 1. Expect `data_out`=0xA5, both error flags 0, and one `done_flag` pulse 1683 cycles after the falling edge (±2 cycles). `active_flag` is high throughout.
2. **Parity error:** send 0x3C with parity 1. Expect `data_out`=0x3C, `parity_error`=1, `frame_error`=0.
3. **Framing error:** send 0x81 with correct parity and stop 0, then hold the line low for 2 bit times, then release it. Expect `frame_error`=1, a single `done_flag`, and no second frame while the line stays low.
4. **Glitch rejection:** pull the line low for 40 cycles (4 ticks), then high. Expect `active_flag` high then low, `done_flag` never asserted, and `data_out` unchanged.
5. **Back-to-back:** send 0x00 then 0xFF with no idle gap. Expect two `done_flag` pulses 1760 cycles apart, with `data_out` = 0x00 then 0xFF and no errors.
6. **Reset mid-frame:** assert `reset` for 1 cycle during data bit 4 of 0x55, then send 0x12. Expect all outputs 0 after reset, no flag for 0x55, and 0x12 received cleanly.
